// File: rtl/bill_slab_accumulator_pkg.sv
// Tariff tables, FSM state encoding and default widths shared by the
// bill slab accumulator, its handshake interface and the testbench.
// Optional feature macro: BILL_FIXED_CHARGE_EN (uses FIXED_CHARGE below).
package bill_pkg;

    localparam int UNIT_W_DEF    = 13;
    localparam int AMT_W_DEF     = 17;
    localparam int NUM_SLABS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slab widths in units; the last slab is unbounded, so its width is never compared.
    localparam logic [NUM_SLABS_DEF-1:0][UNIT_W_DEF-1:0] SLAB_WIDTH =
        {13'd0, 13'd200, 13'd200, 13'd100};

    // Per-unit rate of each slab.
    localparam logic [NUM_SLABS_DEF-1:0][3:0] SLAB_RATE =
        {4'd8, 4'd5, 4'd3, 4'd2};

    // Cost of a fully consumed slab (width * rate); the unbounded slab is never full.
    localparam logic [NUM_SLABS_DEF-1:0][AMT_W_DEF-1:0] SLAB_COST = {
        17'd0,
        AMT_W_DEF'(SLAB_WIDTH[2] * SLAB_RATE[2]),
        AMT_W_DEF'(SLAB_WIDTH[1] * SLAB_RATE[1]),
        AMT_W_DEF'(SLAB_WIDTH[0] * SLAB_RATE[0])
    };

    // Flat charge added to every bill when BILL_FIXED_CHARGE_EN is defined.
    localparam logic [AMT_W_DEF-1:0] FIXED_CHARGE = 17'd50;

endpackage

// File: rtl/bill_slab_accumulator_if.sv
// Request/response handshake between the meter-reading stage, the bill
// slab accumulator and the bill formatter.
interface bill_slab_accumulator_if #(
    parameter int UNIT_W = 13,
    parameter int AMT_W  = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [UNIT_W-1:0] units;
    logic              out_valid;
    logic              out_ready;
    logic [AMT_W-1:0]  amount;
    logic [1:0]        slab_idx;

    modport master (
        output in_valid,
        output units,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  amount,
        input  slab_idx
    );

    modport slave (
        input  in_valid,
        input  units,
        input  out_ready,
        output in_ready,
        output out_valid,
        output amount,
        output slab_idx
    );
endinterface

// File: rtl/bill_slab_accumulator_mag_gt_cmp.sv
// Combinational unsigned a > b magnitude comparator built from per-bit
// gates: a bit position decides the result when all higher bits are equal.
module mag_gt_cmp #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    logic gt_s;
    logic eq_s;

    // Scan from MSB to LSB, carrying "higher bits equal" and "already greater".
    always_comb begin
        gt_s = 1'b0;
        eq_s = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            gt_s = gt_s | (eq_s & a[i] & ~b[i]);
            eq_s = eq_s & ~(a[i] ^ b[i]);
        end
    end

    assign gt = gt_s;

endmodule

// File: rtl/bill_slab_accumulator.sv
// Sequential tariff engine: walks the tariff slabs one per cycle, adding a
// full slab cost while the remaining units exceed the slab width, then the
// partial cost of the last slab touched. Result leaves over valid/ready.
// Optional feature macro: BILL_FIXED_CHARGE_EN adds FIXED_CHARGE to amount.
module bill_slab_accumulator
    import bill_pkg::*;
#(
    parameter int UNIT_W    = UNIT_W_DEF,
    parameter int AMT_W     = AMT_W_DEF,
    parameter int NUM_SLABS = NUM_SLABS_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    bill_slab_accumulator_if.slave bus
);

    state_t            state_r;
    state_t            state_s;

    logic [UNIT_W-1:0] rem_r;
    logic [AMT_W-1:0]  acc_r;
    logic [1:0]        idx_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [AMT_W-1:0]  amount_r;
    logic [1:0]        slab_idx_r;

    logic              accept_s;
    logic              step_s;
    logic              finish_s;
    logic              load_s;
    logic              release_s;
    logic              gt_s;
    logic              not_last_s;
    logic [UNIT_W-1:0] width_s;
    logic [AMT_W-1:0]  prod_s [NUM_SLABS];
    logic [AMT_W-1:0]  result_s;

    // Multiply by a constant rate using only shifted adds of the set rate bits.
    function automatic logic [AMT_W-1:0] rate_mul(input logic [UNIT_W-1:0] val,
                                                   input logic [3:0]        rate);
        logic [AMT_W-1:0] sum;
        sum = {AMT_W{1'b0}};
        for (int b = 0; b < 4; b++) begin
            if (rate[b]) begin
                sum = sum + (AMT_W'(val) << b);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    assign width_s    = SLAB_WIDTH[idx_r];
    assign not_last_s = (idx_r != 2'(NUM_SLABS - 1));

    mag_gt_cmp #(
        .W (UNIT_W)
    ) u_gt (
        .a  (rem_r),
        .b  (width_s),
        .gt (gt_s)
    );

    // One constant-rate product per slab; the active slab picks one below.
    for (genvar g = 0; g < NUM_SLABS; g++) begin : g_prod
        assign prod_s[g] = rate_mul(rem_r, SLAB_RATE[g]);
    end

`ifdef BILL_FIXED_CHARGE_EN
    assign result_s = acc_r + FIXED_CHARGE;
`else
    assign result_s = acc_r;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        step_s    = 1'b0;
        finish_s  = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (not_last_s && gt_s) begin
                    step_s   = 1'b1;
                    state_s  = CALC;
                end else begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end
            end
            DONE: begin
                if (!out_valid_r) begin
                    load_s    = 1'b1;
                    state_s   = DONE;
                end else if (bus.out_ready) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Remaining units, running amount and slab index for the walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= {UNIT_W{1'b0}};
            acc_r <= {AMT_W{1'b0}};
            idx_r <= 2'd0;
        end else if (accept_s) begin
            rem_r <= bus.units;
            acc_r <= {AMT_W{1'b0}};
            idx_r <= 2'd0;
        end else if (step_s) begin
            rem_r <= rem_r - width_s;
            acc_r <= acc_r + SLAB_COST[idx_r];
            idx_r <= idx_r + 2'd1;
        end else if (finish_s) begin
            acc_r <= acc_r + prod_s[idx_r];
        end
    end

    // Registered handshake outputs; results are held until taken downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            amount_r    <= {AMT_W{1'b0}};
            slab_idx_r  <= 2'd0;
        end else begin
            in_ready_r <= (state_s == IDLE);
            if (load_s) begin
                out_valid_r <= 1'b1;
                amount_r    <= result_s;
                slab_idx_r  <= idx_r;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.amount    = amount_r;
    assign bus.slab_idx  = slab_idx_r;

endmodule
